// File: rtl/cross_bar_demux_router.sv
// Header-routed AXI-Stream demux: the first beat selects one of CHANNEL_NO
// per-channel FWFT packet FIFOs; out-of-range destinations are dropped and counted.
module cross_bar_demux_router #(
    parameter int MSEL_WIDTH      = 2,
    parameter int CHANNEL_NO      = 2**MSEL_WIDTH,
    parameter int DATA_WIDTH      = 32,
    parameter int DEST_LSB        = 0,
    parameter int FIFO_ADDR_WIDTH = 5,
    parameter int STRIP_HEADER    = 0,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
    input  logic                             s_axis_tvalid,
    input  logic                             s_axis_tlast,
    output logic                             s_axis_tready,
    output logic [CHANNEL_NO*DATA_WIDTH-1:0] m_axis_tdata,
    output logic [CHANNEL_NO-1:0]            m_axis_tvalid,
    output logic [CHANNEL_NO-1:0]            m_axis_tlast,
    input  logic [CHANNEL_NO-1:0]            m_axis_tready,
    output logic                             busy,
    output logic [CNT_WIDTH-1:0]             drop_count,
    output logic [CHANNEL_NO*CNT_WIDTH-1:0]  pkt_count,
    output logic [1:0]                       dbg_state
);

    localparam int DEPTH = 2**FIFO_ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DROP   = 2'd2
    } state_t;

    state_t                  r_state;
    logic [MSEL_WIDTH-1:0]   r_dest;
    logic [CNT_WIDTH-1:0]    r_drop_cnt;

    logic [MSEL_WIDTH-1:0]   w_hdr_dest;
    logic                    w_hdr_ok;
    logic [CHANNEL_NO-1:0]   w_dest_sel;
    logic [CHANNEL_NO-1:0]   w_full;
    logic [CHANNEL_NO-1:0]   w_push;
    logic                    w_dest_full;
    logic                    w_tready;
    logic                    w_accept;

    assign w_hdr_dest = s_axis_tdata[DEST_LSB +: MSEL_WIDTH];
    assign w_hdr_ok   = ({1'b0, w_hdr_dest} < (MSEL_WIDTH+1)'(CHANNEL_NO));

    always_comb begin
        w_dest_sel = '0;
        for (int c = 0; c < CHANNEL_NO; c++) begin
            w_dest_sel[c] = (r_dest == MSEL_WIDTH'(c));
        end
    end

    assign w_dest_full = |(w_full & w_dest_sel);

    // Handshake: a beat moves on a port exactly in the cycle where tvalid and
    // tready are both high at the rising edge; tready never depends on tvalid.
    always_comb begin
        w_tready = 1'b0;
        if (!areset) begin
            case (r_state)
                ST_IDLE:   w_tready = (STRIP_HEADER != 0);
                ST_ACTIVE: w_tready = !w_dest_full;
                ST_DROP:   w_tready = 1'b1;
                default:   w_tready = 1'b0;
            endcase
        end
    end

    assign w_accept      = s_axis_tvalid & w_tready;
    assign w_push        = {CHANNEL_NO{(r_state == ST_ACTIVE) && w_accept}} & w_dest_sel;
    assign s_axis_tready = w_tready;
    assign busy          = (r_state != ST_IDLE);
    assign drop_count    = r_drop_cnt;
    assign dbg_state     = r_state;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state    <= ST_IDLE;
            r_dest     <= '0;
            r_drop_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_axis_tvalid) begin
                        r_dest <= w_hdr_dest;
                        // A stripped header carrying tlast is a packet with no payload.
                        if ((STRIP_HEADER != 0) && s_axis_tlast) begin
                            if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
                        end else begin
                            r_state <= w_hdr_ok ? ST_ACTIVE : ST_DROP;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (w_accept && s_axis_tlast) r_state <= ST_IDLE;
                end
                ST_DROP: begin
                    if (w_accept && s_axis_tlast) begin
                        r_state <= ST_IDLE;
                        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < CHANNEL_NO; c++) begin : g_ch
        logic [DATA_WIDTH:0]        r_mem [DEPTH];
        logic [FIFO_ADDR_WIDTH-1:0] r_wr_ptr;
        logic [FIFO_ADDR_WIDTH-1:0] r_rd_ptr;
        logic [FIFO_ADDR_WIDTH:0]   r_count;
        logic [CNT_WIDTH-1:0]       r_pkt_cnt;
        logic                       w_valid;
        logic                       w_pop;
        logic [DATA_WIDTH:0]        w_head;

        assign w_valid   = (r_count != '0);
        assign w_pop     = w_valid & m_axis_tready[c];
        assign w_full[c] = (r_count == (FIFO_ADDR_WIDTH+1)'(DEPTH));
        assign w_head    = r_mem[r_rd_ptr];

        always_ff @(posedge aclk) begin
            if (w_push[c]) r_mem[r_wr_ptr] <= {s_axis_tlast, s_axis_tdata};
        end

        always_ff @(posedge aclk) begin
            if (areset) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_count   <= '0;
                r_pkt_cnt <= '0;
            end else begin
                if (w_push[c]) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_push[c], w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
                if (w_push[c] && s_axis_tlast && (r_pkt_cnt != '1)) begin
                    r_pkt_cnt <= r_pkt_cnt + 1'b1;
                end
            end
        end

        // Empty FIFO presents zero so stale memory never reaches the output.
        assign m_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH] = w_valid ? w_head[DATA_WIDTH-1:0] : '0;
        assign m_axis_tlast[c]                          = w_valid & w_head[DATA_WIDTH];
        assign m_axis_tvalid[c]                         = w_valid;
        assign pkt_count[c*CNT_WIDTH +: CNT_WIDTH]      = r_pkt_cnt;
    end

endmodule

// File: doc/cross_bar_demux_router.md
Name: cross_bar_demux_router

Overview:
Parametrised successor of the per-input header-routed demux stage of the MxN cross-bar. It accepts one AXI-Stream input and reads the destination channel from a configurable field of the first beat. The packet is routed into one of CHANNEL_NO per-channel packet FIFOs, with optional header stripping. Packets with an out-of-range destination are dropped and counted instead of being misrouted.

Parameters:
MSEL_WIDTH, 2, width of destination field
CHANNEL_NO, 2**MSEL_WIDTH, number of output channels; may be less than 2**MSEL_WIDTH
DATA_WIDTH, 32, tdata width
DEST_LSB, 0, bit position of destination field in header beat; DEST_LSB+MSEL_WIDTH <= DATA_WIDTH
FIFO_ADDR_WIDTH, 5, per-channel FIFO depth = 2**FIFO_ADDR_WIDTH beats
STRIP_HEADER, 0, 1 = header beat consumed and not forwarded
CNT_WIDTH, 16, width of status counters

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
s_axis_tdata  in  DATA_WIDTH  input data
s_axis_tvalid  in  1  input valid
s_axis_tlast  in  1  input end of packet
s_axis_tready  out  1  input ready
m_axis_tdata  out  [CHANNEL_NO] x DATA_WIDTH  per-channel data
m_axis_tvalid  out  [CHANNEL_NO] x 1  per-channel valid
m_axis_tlast  out  [CHANNEL_NO] x 1  per-channel last
m_axis_tready  in  [CHANNEL_NO] x 1  per-channel ready
busy  out  1  high while state != IDLE
drop_count  out  CNT_WIDTH  packets dropped since reset, saturating
pkt_count  out  [CHANNEL_NO] x CNT_WIDTH  packets written per channel, saturating

Behaviour:
- Clock and reset: single clock aclk. areset is synchronous and active-high.
- Reset values: state=IDLE; all FIFOs empty; s_axis_tready=0; m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0; busy=0; all counters=0.
- Destination: dest = s_axis_tdata[DEST_LSB +: MSEL_WIDTH], latched in IDLE. A destination is valid iff dest < CHANNEL_NO.
- State IDLE, STRIP_HEADER=0:
  - s_axis_tready=0.
  - On s_axis_tvalid, latch dest and go to ACTIVE if valid, else DROP.
  - The header beat is not consumed; it is re-presented and forwarded in ACTIVE. One bubble cycle per packet.
- State IDLE, STRIP_HEADER=1:
  - s_axis_tready=1.
  - On s_axis_tvalid the header beat is consumed, not written to any FIFO, and dest is latched.
  - If tlast=0: go to ACTIVE if valid, else DROP.
  - If tlast=1 (header-only packet): stay IDLE and drop_count+1.
- State ACTIVE:
  - s_axis_tready = not full of FIFO[dest]. No other FIFO is written.
  - A beat is accepted when tvalid & tready; it is written {tdata, tlast} into FIFO[dest].
  - On an accepted beat with tlast: pkt_count[dest]+1, then IDLE the next cycle.
- State DROP:
  - s_axis_tready=1 and beats are discarded.
  - On an accepted beat with tlast: drop_count+1, then IDLE.
- FIFO: first-word-fall-through.
  - A beat written at edge t is visible on m_axis_* after edge t (one-cycle latency).
  - Pop on m_axis_tvalid & m_axis_tready.
  - Full at 2**FIFO_ADDR_WIDTH entries. Push and pop in the same cycle are both honoured, occupancy unchanged.
  - Full blocks input only (no bypass). Empty forces m_axis_tvalid=0.
  - Pointers wrap modulo depth; occupancy counter is FIFO_ADDR_WIDTH+1 bits.
- Back-pressure: a stalled output channel stalls only packets destined for it. Other channels keep draining their FIFOs.
- Counters saturate at all-ones and never wrap.
- Reset mid-packet: FIFO contents are discarded and the FSM returns to IDLE. The next input beat is treated as a header; upstream must also be reset.
- Inputs: tdata is ignored while tvalid=0. X on tlast when tvalid=0 must not affect state.

Test Plan:
- CHANNEL_NO=4, STRIP_HEADER=0: 3-beat packet header 0x00000002, then 0xA, 0xB (tlast) -> channel 2 outputs 0x2, 0xA, 0xB with tlast on 0xB; other channels tvalid=0; pkt_count[2]=1; tready low for exactly 1 cycle at header.
- CHANNEL_NO=3, MSEL_WIDTH=2: header dest=3, 4-beat packet -> tready=1 for all 4 beats, no m_axis_tvalid, drop_count=1, busy drops to 0 after tlast.
- STRIP_HEADER=1, DEST_LSB=8: header 0x00000100, then 0x11 (tlast) -> channel 1 outputs only 0x11 with tlast; single-beat header+tlast packet -> drop_count+1, nothing forwarded.
- FIFO_ADDR_WIDTH=2: 10-beat packet to channel 0 with m_axis_tready[0]=0 -> exactly 4 beats accepted, then s_axis_tready=0. Release ready -> all 10 beats delivered in order; a following packet to channel 1 flows only after the channel 0 packet completes.
- Back-to-back packets to channels 1, 3, 1 with random m_axis_tready -> per-channel order preserved, pkt_count={0,2,0,1}.
- Assert areset for 1 cycle mid-packet -> next cycle all m_axis_tvalid=0, counters=0, state IDLE, busy=0.
